// File: rtl/mem_stage_controller.sv
// mem_stage_controller: issues the MEM-stage load/store as a single-outstanding
// req/ack bus transaction, stalling the pipeline until it completes.
// Optional feature macro: MEM_TIMEOUT_EN (REQ timeout with busError_MEM pulse).
module mem_stage_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memWrite_MEM,
  input  logic        memRead_MEM,
  input  logic [2:0]  funct3_MEM,
  input  logic [31:0] ALUResult_MEM,
  input  logic [31:0] storeOut_MEM,
  input  logic        busAck,
  input  logic [31:0] busRData,
  output logic        stall_MEM,
  output logic        busReq,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [3:0]  busByteEn,
  output logic [31:0] busWData,
  output logic [31:0] loadData_MEM,
  output logic        misalign_MEM,
  output logic        busError_MEM
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        op_c;
  logic        mis_c;
  logic        go_c;
  logic        timeout_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;

  // Shift the read word down to the addressed lane, then size and extend it
  function automatic logic [31:0] extract(input logic [31:0] d,
                                          input logic [1:0]  off,
                                          input logic [2:0]  f3);
    logic [31:0] sh;
    sh = d >> {off, 3'b000};
    case (f3[1:0])
      2'b00:   extract = f3[2] ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   extract = f3[2] ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: extract = sh;
    endcase
  endfunction

  // Lane enables, replicated store data and alignment check for the incoming op
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = storeOut_MEM;
    mis_c   = 1'b0;
    case (funct3_MEM[1:0])
      2'b00: begin
        be_c    = 4'b0001 << ALUResult_MEM[1:0];
        wdata_c = {4{storeOut_MEM[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << ALUResult_MEM[1:0];
        wdata_c = {2{storeOut_MEM[15:0]}};
        mis_c   = ALUResult_MEM[0];
      end
      default: begin
        mis_c   = |ALUResult_MEM[1:0];
      end
    endcase
  end

  assign op_c         = memWrite_MEM | memRead_MEM;
  assign go_c         = (state == IDLE) && op_c && !mis_c;
  assign stall_MEM    = !rst && (go_c || (state == REQ));
  assign misalign_MEM = !rst && (state == IDLE) && op_c && mis_c;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] to_cnt;

  // Count unacknowledged REQ cycles; held at zero outside REQ
  always_ff @(posedge clk) begin
    if (rst || (state != REQ)) to_cnt <= 8'd0;
    else if (!busAck)          to_cnt <= to_cnt + 8'd1;
  end

  assign timeout_c = (state == REQ) && !busAck && (to_cnt == TO_LAST);
`else
  logic [7:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 8'(TIMEOUT_CYCLES);
  assign timeout_c          = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; DONE always returns to IDLE so an op is never re-issued
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go_c) state_nxt = REQ;
      REQ:     if (busAck || timeout_c) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered bus outputs, load result and error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      busReq       <= 1'b0;
      busWe        <= 1'b0;
      busAddr      <= 32'd0;
      busByteEn    <= 4'd0;
      busWData     <= 32'd0;
      loadData_MEM <= 32'd0;
      busError_MEM <= 1'b0;
      off_q        <= 2'd0;
      f3_q         <= 3'd0;
    end else begin
      busError_MEM <= 1'b0;
      case (state)
        IDLE: begin
          if (go_c) begin
            busReq    <= 1'b1;
            busWe     <= memWrite_MEM;
            busAddr   <= {ALUResult_MEM[31:2], 2'b00};
            busByteEn <= be_c;
            busWData  <= wdata_c;
            off_q     <= ALUResult_MEM[1:0];
            f3_q      <= funct3_MEM;
          end
        end
        REQ: begin
          if (busAck) begin
            busReq <= 1'b0;
            if (!busWe) loadData_MEM <= extract(busRData, off_q, f3_q);
          end else if (timeout_c) begin
            busReq       <= 1'b0;
            busError_MEM <= 1'b1;
            if (!busWe) loadData_MEM <= 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_controller.sv
// Directed bench for mem_stage_controller with a load-result scoreboard.
module tb_mem_stage_controller;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        memWrite_MEM, memRead_MEM;
  logic [2:0]  funct3_MEM;
  logic [31:0] ALUResult_MEM, storeOut_MEM;
  logic        busAck;
  logic [31:0] busRData;
  logic        stall_MEM, busReq, busWe;
  logic [31:0] busAddr, busWData, loadData_MEM;
  logic [3:0]  busByteEn;
  logic        misalign_MEM, busError_MEM;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_load = 32'd0;

  mem_stage_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .memWrite_MEM(memWrite_MEM), .memRead_MEM(memRead_MEM),
    .funct3_MEM(funct3_MEM), .ALUResult_MEM(ALUResult_MEM),
    .storeOut_MEM(storeOut_MEM), .busAck(busAck), .busRData(busRData),
    .stall_MEM(stall_MEM), .busReq(busReq), .busWe(busWe),
    .busAddr(busAddr), .busByteEn(busByteEn), .busWData(busWData),
    .loadData_MEM(loadData_MEM), .misalign_MEM(misalign_MEM),
    .busError_MEM(busError_MEM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete aligned access; waits = ack-less REQ cycles before the ack
  task automatic do_access(input string tag, input logic we, input logic rd,
                           input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [31:0] rdata,
                           input int waits, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd, input logic [31:0] exp_ld);
    int          stalls;
    logic [31:0] exp;
    @(negedge clk);
    memWrite_MEM = we; memRead_MEM = rd; funct3_MEM = f3;
    ALUResult_MEM = addr; storeOut_MEM = sd; busAck = 1'b0;
    if (!we) exp_q.push_back(exp_ld);
    #1;
    stalls = stall_MEM ? 1 : 0;
    chk({tag, "/misalign"}, 32'(misalign_MEM), 32'd0);
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      chk({tag, "/req"}, 32'(busReq), 32'd1);
      if (stall_MEM) stalls++;
      if (i == 0) begin
        chk({tag, "/addr"}, busAddr, addr & 32'hFFFF_FFFC);
        chk({tag, "/be"}, 32'(busByteEn), 32'(exp_be));
        chk({tag, "/we"}, 32'(busWe), 32'(we));
        if (we) chk({tag, "/wdata"}, busWData, exp_wd);
      end
      if (i == waits) begin
        busAck = 1'b1; busRData = rdata;
      end
    end
    @(negedge clk);
    busAck = 1'b0; busRData = $urandom;
    chk({tag, "/done_req"}, 32'(busReq), 32'd0);
    chk({tag, "/done_stall"}, 32'(stall_MEM), 32'd0);
    chk({tag, "/err"}, 32'(busError_MEM), 32'd0);
    if (!we) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL %s/sb: observed empty scoreboard expected entry", tag);
        exp = last_load;
      end else begin
        exp = exp_q.pop_front();
      end
      last_load = exp;
    end else begin
      exp = last_load;
    end
    chk({tag, "/load"}, loadData_MEM, exp);
    chk({tag, "/stalls"}, 32'(stalls), 32'(waits + 2));
    memWrite_MEM = 1'b0; memRead_MEM = 1'b0;
    @(negedge clk);
    chk({tag, "/idle_stall"}, 32'(stall_MEM), 32'd0);
    chk({tag, "/idle_req"}, 32'(busReq), 32'd0);
  endtask

  // Misaligned op: no bus activity, no stall, one-cycle misalign flag
  task automatic do_misalign(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr);
    @(negedge clk);
    memWrite_MEM = we; memRead_MEM = !we; funct3_MEM = f3; ALUResult_MEM = addr;
    #1;
    chk({tag, "/flag"}, 32'(misalign_MEM), 32'd1);
    chk({tag, "/stall"}, 32'(stall_MEM), 32'd0);
    @(negedge clk);
    chk({tag, "/req"}, 32'(busReq), 32'd0);
    chk({tag, "/load"}, loadData_MEM, last_load);
    memWrite_MEM = 1'b0; memRead_MEM = 1'b0;
    #1;
    chk({tag, "/flag_clr"}, 32'(misalign_MEM), 32'd0);
  endtask

  initial begin
    rst = 1'b1; memWrite_MEM = 1'b0; memRead_MEM = 1'b1; funct3_MEM = 3'd2;
    ALUResult_MEM = 32'h100; storeOut_MEM = 32'd0; busAck = 1'b0; busRData = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst/stall", 32'(stall_MEM), 32'd0);
    chk("rst/req", 32'(busReq), 32'd0);
    chk("rst/load", loadData_MEM, 32'd0);
    chk("rst/wdata", busWData, 32'd0);
    memRead_MEM = 1'b0; rst = 1'b0;

    do_access("lw",  1'b0, 1'b1, 3'd2, 32'h100, 32'd0, 32'hDEADBEEF, 0, 4'b1111, 32'd0, 32'hDEADBEEF);
    do_access("lb",  1'b0, 1'b1, 3'd0, 32'h203, 32'd0, 32'h80FF7F01, 0, 4'b1000, 32'd0, 32'hFFFFFF80);
    do_access("lbu", 1'b0, 1'b1, 3'd4, 32'h203, 32'd0, 32'h80FF7F01, 1, 4'b1000, 32'd0, 32'h00000080);
    do_access("sh",  1'b1, 1'b0, 3'd1, 32'h042, 32'h1234ABCD, 32'd0, 3, 4'b1100, 32'hABCDABCD, 32'd0);
    do_access("lh",  1'b0, 1'b1, 3'd1, 32'h102, 32'd0, 32'h80FF7F01, 0, 4'b1100, 32'd0, 32'hFFFF80FF);
    do_access("lhu", 1'b0, 1'b1, 3'd5, 32'h102, 32'd0, 32'h80FF7F01, 2, 4'b1100, 32'd0, 32'h000080FF);
    do_access("lb0", 1'b0, 1'b1, 3'd0, 32'h300, 32'd0, 32'h80FF7F01, 0, 4'b0001, 32'd0, 32'h00000001);
    do_access("sb",  1'b1, 1'b0, 3'd0, 32'h001, 32'h0000005A, 32'd0, 0, 4'b0010, 32'h5A5A5A5A, 32'd0);
    do_access("sw",  1'b1, 1'b0, 3'd2, 32'h010, 32'hCAFEF00D, 32'd0, 1, 4'b1111, 32'hCAFEF00D, 32'd0);
    do_access("rw",  1'b1, 1'b1, 3'd2, 32'h014, 32'h01234567, 32'd0, 0, 4'b1111, 32'h01234567, 32'd0);

    do_misalign("mis_lw", 1'b0, 3'd2, 32'h102);
    do_misalign("mis_sh", 1'b1, 3'd1, 32'h041);

    // Stray ack while idle must not start or disturb anything
    @(negedge clk);
    busAck = 1'b1; busRData = 32'h11111111;
    @(negedge clk);
    busAck = 1'b0;
    chk("stray/req", 32'(busReq), 32'd0);
    chk("stray/load", loadData_MEM, last_load);

`ifdef MEM_TIMEOUT_EN
    begin
      int reqs;
      @(negedge clk);
      memRead_MEM = 1'b1; funct3_MEM = 3'd2; ALUResult_MEM = 32'h500;
      reqs = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (!busReq) break;
        reqs++;
      end
      chk("to/req_cycles", 32'(reqs), 32'(TO));
      chk("to/err", 32'(busError_MEM), 32'd1);
      chk("to/load", loadData_MEM, 32'd0);
      chk("to/stall", 32'(stall_MEM), 32'd0);
      memRead_MEM = 1'b0;
      last_load = 32'd0;
      @(negedge clk);
      chk("to/err_clr", 32'(busError_MEM), 32'd0);
    end
`endif

    // Reset while a request is outstanding
    @(negedge clk);
    memRead_MEM = 1'b1; funct3_MEM = 3'd2; ALUResult_MEM = 32'h600;
    @(negedge clk);
    chk("rstreq/req_before", 32'(busReq), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstreq/stall_in_rst", 32'(stall_MEM), 32'd0);
    @(negedge clk);
    chk("rstreq/req", 32'(busReq), 32'd0);
    chk("rstreq/addr", busAddr, 32'd0);
    chk("rstreq/be", 32'(busByteEn), 32'd0);
    chk("rstreq/load", loadData_MEM, 32'd0);
    memRead_MEM = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rstreq/stall_after", 32'(stall_MEM), 32'd0);
    chk("rstreq/req_after", 32'(busReq), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_controller.md
Name: mem_stage_controller

Overview:
- Sequences every load/store held in the EX/MEM pipeline register onto a single-outstanding request/acknowledge data-memory bus.
- Freezes the pipeline with `stall_MEM` until the access completes.
- Forms byte lanes, store-data replication and load extraction with sign or zero extension.
- Sits between the MEM-stage register outputs and the data memory / SDRAM front end; `loadData_MEM` feeds the writeback mux.

Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum `REQ` cycles without `busAck` before error. Used only with `MEM_TIMEOUT_EN`; range 1..255.

Ports:
- `clk  input  1`: clock, rising edge
- `rst  input  1`: reset, synchronous, active-high
- `memWrite_MEM  input  1`: store in MEM stage
- `memRead_MEM  input  1`: load in MEM stage (decoded from `resultSrc_MEM==2'b01`)
- `funct3_MEM  input  3`: access size/sign (0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU)
- `ALUResult_MEM  input  32`: byte address
- `storeOut_MEM  input  32`: store data, LSB-aligned
- `busAck  input  1`: memory completes current request this cycle
- `busRData  input  32`: read data, valid when `busAck`=1
- `stall_MEM  output  1`: freeze PC, IF/ID, ID/EX and EX/MEM registers
- `busReq  output  1`: request valid
- `busWe  output  1`: 1 = write
- `busAddr  output  32`: word address, `{ALUResult[31:2],2'b00}`
- `busByteEn  output  4`: lane enables
- `busWData  output  32`: lane-replicated store data
- `loadData_MEM  output  32`: extended load result
- `misalign_MEM  output  1`: misaligned access pulse
- `busError_MEM  output  1`: timeout pulse (tied 0 without macro)

Behaviour:
- Reset: synchronous, active-high; on the next edge the FSM goes to `IDLE`.
  - Registered outputs clear: `busReq`=0, `busWe`=0, `busAddr`=0, `busByteEn`=0, `busWData`=0, `loadData_MEM`=0, `busError_MEM`=0, `misalign_MEM`=0.
  - `stall_MEM` is 0 while `rst`=1.
  - Reset mid-`REQ` drops `busReq` at that edge; memory must tolerate an abandoned request.
- States: `IDLE`, `REQ`, `DONE`.
- `IDLE`:
  - op = `memWrite_MEM|memRead_MEM`. If both are set, treat as a store.
  - Aligned op: `stall_MEM`=1 combinationally. On the next edge go to `REQ` and register `busReq`=1, `busWe`, `busAddr`, `busByteEn`, `busWData`.
  - Misaligned op (half with `addr[0]`=1, word with `addr[1:0]`≠0): no bus access, no stall. `misalign_MEM`=1 for the cycle (combinational); `loadData_MEM` is held.
  - No op: `stall_MEM`=0.
- `REQ`:
  - `stall_MEM`=1; bus outputs stable.
  - On an edge with `busAck`=1: go to `DONE`, `busReq`→0. For a load, capture extracted `busRData` into `loadData_MEM`.
- `DONE`:
  - `stall_MEM`=0 for exactly one cycle, so the pipeline advances at the next edge.
  - Next state is unconditionally `IDLE`, so the same instruction is never re-issued.
  - `loadData_MEM` holds until the next load completes.
- Latency: minimum 3 cycles per access (detect, `REQ` with immediate ack, `DONE`), giving 2 stall cycles. Each extra ack wait adds one stall cycle.
- Byte enables:
  - Byte: `1<<addr[1:0]`.
  - Half: `4'b0011<<addr[1:0]`.
  - Word: `4'b1111`.
- Store data: byte `{4{d[7:0]}}`, half `{2{d[15:0]}}`, word `d`.
- Load extraction:
  - Shift `busRData` right by `addr[1:0]*8`.
  - Take 8/16/32 bits.
  - `funct3[2]`=1 zero-extends; otherwise sign-extends.
- `busAck` outside `REQ` is ignored.

Optional Feature:
- Macro: `MEM_TIMEOUT_EN`.
- Defined:
  - An 8-bit counter clears on entry to `REQ` and increments each `REQ` cycle without ack.
  - When the count reaches `TIMEOUT_CYCLES`, the next edge goes to `DONE`, drops `busReq`, sets `loadData_MEM`=0 for loads, and pulses `busError_MEM`=1 for the `DONE` cycle.
  - Ack on the same edge as the limit takes priority: normal completion, no error.
- Not defined: `REQ` waits indefinitely; `busError_MEM` is constant 0; no counter is present.

Test Plan:
- LW, `addr 0x100`, ack in first `REQ` cycle, `busRData 0xDEADBEEF` -> `busAddr 0x100`, `busByteEn 1111`, `busWe` 0; `stall_MEM` high 2 cycles; `loadData_MEM 0xDEADBEEF` in `DONE`.
- LB `addr 0x203` and LBU `addr 0x203`, `busRData 0x80FF7F01` -> `busByteEn 1000`; LB gives `0xFFFFFF80`, LBU gives `0x00000080`.
- SH `addr 0x42`, `storeOut 0x1234ABCD`, ack after 3 wait cycles -> `busWData 0xABCDABCD`, `busByteEn 1100`, `busWe` 1; stall 5 cycles total; `DONE` then `IDLE`.
- LW `addr 0x102` -> `misalign_MEM`=1 one cycle, `busReq` never asserted, `stall_MEM`=0.
- `rst` asserted during `REQ` -> next edge `busReq`=0, state `IDLE`, `stall_MEM`=0, all registered outputs 0.
- `MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, no ack -> `busReq` drops after 4 `REQ` cycles; `busError_MEM` pulses 1 cycle; `loadData_MEM`=0; pipeline released.
